in_deser: RTL and testbench
===========================

Name: in_deser

Overview:
- Serial-to-parallel stage directly downstream of the registered input pad cell.
- Consumes the registered bit stream plus a per-bit qualifier and a word-alignment marker, and assembles WIDTH-bit words.
- Delivers words on a valid/ready interface through a 2-entry output buffer.
- Sits between the IO input register and fabric logic. Provides framing and overflow/frame-error status for soft IO protocols.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 0, 0 = first accepted bit lands in out_data[0]; 1 = first bit lands in out_data[WIDTH-1].

Ports:
- clk  input  1  fabric clock, shared with the upstream input register.
- rst  input  1  synchronous, active-high reset.
- dataIn  input  1  serial bit from the upstream register output.
- sel  input  1  bit qualifier; dataIn is accepted only on edges where sel=1.
- sync  input  1  word-start marker; meaningful only when sel=1.
- out_data  output  WIDTH  oldest buffered word.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts the word.
- aligned  output  1  block is in SHIFT state.
- overflow  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: sync arrived mid-word.
- err_clr  input  1  clears overflow and frame_err.

Behaviour:
- Reset and clocking:
  - One clock domain.
  - rst is synchronous and active-high, sampled on the rising clk edge. It has priority over all other inputs.
  - Reset values: state=HUNT, bit counter=0, buffer occupancy=0, out_valid=0, out_data=0, aligned=0, overflow=0, frame_err=0.
  - Reset mid-word discards the partial word. Reset with buffered words discards them.
- Accept and pop events:
  - accept = sel. Cycles with sel=0 change nothing in the shifter or counter. sync with sel=0 is ignored.
  - pop = out_valid & out_ready.
- State machine, 2 states:
  - HUNT:
    - accept & ~sync: bit discarded.
    - accept & sync: bit stored as word bit 0, counter=1, go to SHIFT.
  - SHIFT:
    - accept & ~sync: store bit at position counter, counter+1.
    - accept with counter==WIDTH-1: word complete, counter=0, stay in SHIFT. Framing is continuous and the next word needs no sync.
    - accept & sync & counter==0: normal word start, no error.
    - accept & sync & counter!=0: partial word discarded, this bit becomes bit 0, counter=1, frame_err set.
- Bit ordering:
  - MSB_FIRST=0: bit k lands in out_data[k].
  - MSB_FIRST=1: bit k lands in out_data[WIDTH-1-k].
- Latency:
  - A completed word is written into the buffer on the same edge that samples its last bit.
  - out_valid is therefore high in the cycle after that edge when the buffer was empty.
- Output buffer (2-entry FIFO):
  - out_data always shows the oldest entry. out_data is stable while out_valid=1 and out_ready=0.
  - push & pop in the same cycle is always accepted, at any occupancy.
  - push with occupancy 2 and no pop: new word dropped, overflow set, buffer contents unchanged.
  - When the buffer becomes empty, out_data holds its last value (don't-care to consumers).
- Sticky flags:
  - err_clr clears overflow and frame_err on the next edge.
  - If a set event and err_clr occur in the same cycle, set wins.
- aligned = (state==SHIFT). It is never cleared except by rst.
- Counter width: clog2(WIDTH). The counter never exceeds WIDTH-1.

Test Plan:
- Basic word: WIDTH=8, MSB_FIRST=0, out_ready=1.
  - Stimulus: sel=1 every cycle, sync with the first bit, bits 1,0,1,0,0,1,0,1.
  - Response: out_data=8'hA5, out_valid high exactly one cycle, starting 1 cycle after the 8th bit edge. aligned=1 from the cycle after the first bit.
- Hunt discard and gaps:
  - Stimulus: 3 accepted bits without sync, then sync plus 0xA5 with sel=0 gaps inserted between bits.
  - Response: single word 8'hA5, no errors.
- MSB_FIRST=1:
  - Stimulus: same bit sequence as the basic word.
  - Response: out_data=8'hA5 reversed = 8'hA5 (palindrome check); then the sequence for 0x01 yields 8'h80.
- Backpressure/overflow: out_ready=0, stream three words 0x11, 0x22, 0x33.
  - Response: first two words buffered, third dropped, overflow=1.
  - Then raise out_ready: reads return 0x11 then 0x22, and out_valid drops.
  - err_clr then clears overflow.
- Mid-word sync:
  - Stimulus: after 4 bits of a word, sync+sel, followed by a full 0x3C.
  - Response: frame_err=1, next delivered word=8'h3C, no partial word emitted.
- Reset mid-operation:
  - Stimulus: rst high for one cycle after 5 bits with one word buffered.
  - Response: out_valid=0, aligned=0, counter=0.
  - Bits without sync after reset are discarded.

Source files
------------

// File: rtl/in_deser.sv
// in_deser: serial-to-parallel word assembler with sync framing and a 2-entry output buffer
module in_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dataIn,
    input  logic             sel,
    input  logic             sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             aligned,
    output logic             overflow,
    output logic             frame_err,
    input  logic             err_clr
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {HUNT, SHIFT} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] mem_q [2];
    logic [1:0]       occ_q, occ_d;
    logic             rd_q, rd_d;
    logic             ovf_q, ovf_d, ferr_q, ferr_d;
    logic             push, ferr_set, pop, full, wr_en, wr_idx;
    function automatic logic [CW-1:0] bit_pos(input logic [CW-1:0] k);
        return MSB_FIRST ? CW'(WIDTH - 1) - k : k;
    endfunction
    // framing FSM: hunt for sync, then place each accepted bit and flag word completion
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        if (sel && sync) begin
            shift_d[bit_pos('0)] = dataIn;
            cnt_d    = CW'(1);
            state_d  = SHIFT;
            ferr_set = (state_q == SHIFT) && (cnt_q != '0);
        end else if (sel && state_q == SHIFT) begin
            shift_d[bit_pos(cnt_q)] = dataIn;
            push  = (cnt_q == CW'(WIDTH - 1));
            cnt_d = push ? '0 : cnt_q + 1'b1;
        end
    end
    // buffer bookkeeping: read slot only advances when a word remains behind it
    always_comb begin
        pop    = out_valid & out_ready;
        full   = (occ_q == 2'd2);
        wr_en  = push & (~full | pop);
        wr_idx = rd_q ^ occ_q[0];
        occ_d  = occ_q + 2'(wr_en) - 2'(pop);
        rd_d   = (pop && (full || wr_en)) ? ~rd_q : rd_q;
        ovf_d  = (push & full & ~pop) | (ovf_q & ~err_clr);
        ferr_d = ferr_set | (ferr_q & ~err_clr);
    end
    // state, shifter, buffer and sticky flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            shift_q <= '0;
            mem_q   <= '{default: '0};
            occ_q   <= '0;
            rd_q    <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            if (wr_en) mem_q[wr_idx] <= shift_d;
            occ_q   <= occ_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end
    assign out_data  = mem_q[rd_q];
    assign out_valid = (occ_q != 2'd0);
    assign aligned   = (state_q == SHIFT);
    assign overflow  = ovf_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_in_deser.sv
// tb_in_deser: directed checks of framing, bit order, buffering, flags and reset
module tb_in_deser;
    logic clk = 1'b0;
    logic rst, dataIn, sel, sync, out_ready, err_clr;
    logic [7:0] d0, d1;
    logic v0, v1, a0, a1, o0, o1, f0, f1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    in_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u0 (
        .clk(clk), .rst(rst), .dataIn(dataIn), .sel(sel), .sync(sync),
        .out_data(d0), .out_valid(v0), .out_ready(out_ready),
        .aligned(a0), .overflow(o0), .frame_err(f0), .err_clr(err_clr)
    );
    in_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst(rst), .dataIn(dataIn), .sel(sel), .sync(sync),
        .out_data(d1), .out_valid(v1), .out_ready(out_ready),
        .aligned(a1), .overflow(o1), .frame_err(f1), .err_clr(err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        sel = 1'b1;
        dataIn = b;
        sync = s;
        tick();
        sel = 1'b0;
        sync = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic s, input int gap);
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i], s && (i == 0));
            if (i < 7) repeat (gap) tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", v0); end
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", d0); end
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL reset_aligned got=%b exp=0", a0); end
        checks++; if (o0 !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", o0); end
        checks++; if (f0 !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", f0); end
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'hA5;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i], i == 0);
            if (i == 0) begin
                checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL basic_aligned got=%b exp=1", a0); end
            end
            if (i == 6) begin
                checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", v0); end
            end
        end
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", v0); end
        checks++; if (d0 !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", d0); end
        checks++; if (d1 !== 8'hA5) begin errors++; $display("FAIL msb_palindrome got=%h exp=a5", d1); end
        tick();
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", v0); end
    endtask

    task automatic test_msb();
        do_reset();
        out_ready = 1'b1;
        send_word(8'h01, 1'b1, 0);
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL msb_valid got=%b exp=1", v1); end
        checks++; if (d1 !== 8'h80) begin errors++; $display("FAIL msb_data got=%h exp=80", d1); end
        checks++; if (d0 !== 8'h01) begin errors++; $display("FAIL lsb_data got=%h exp=01", d0); end
    endtask

    task automatic test_hunt();
        do_reset();
        out_ready = 1'b1;
        repeat (3) send_bit(1'b1, 1'b0);
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL hunt_aligned got=%b exp=0", a0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL hunt_valid got=%b exp=0", v0); end
        send_word(8'hA5, 1'b1, 1);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL gap_valid got=%b exp=1", v0); end
        checks++; if (d0 !== 8'hA5) begin errors++; $display("FAIL gap_data got=%h exp=a5", d0); end
        checks++; if (o0 !== 1'b0 || f0 !== 1'b0) begin errors++; $display("FAIL gap_flags got=%b%b exp=00", o0, f0); end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        send_word(8'h11, 1'b1, 0);
        send_word(8'h22, 1'b0, 0);
        checks++; if (o0 !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", o0); end
        checks++; if (d0 !== 8'h11) begin errors++; $display("FAIL ovf_hold got=%h exp=11", d0); end
        send_word(8'h33, 1'b0, 0);
        checks++; if (o0 !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", o0); end
        checks++; if (v0 !== 1'b1 || d0 !== 8'h11) begin errors++; $display("FAIL ovf_read1 got=%b/%h exp=1/11", v0, d0); end
        out_ready = 1'b1;
        tick();
        checks++; if (v0 !== 1'b1 || d0 !== 8'h22) begin errors++; $display("FAIL ovf_read2 got=%b/%h exp=1/22", v0, d0); end
        tick();
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", v0); end
        checks++; if (o0 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", o0); end
        out_ready = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (o0 !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", o0); end
    endtask

    task automatic test_midword();
        logic [7:0] w;
        w = 8'h3C;
        do_reset();
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++; if (f0 !== 1'b0) begin errors++; $display("FAIL mid_ferr_early got=%b exp=0", f0); end
        err_clr = 1'b1;
        send_bit(w[0], 1'b1);
        err_clr = 1'b0;
        checks++; if (f0 !== 1'b1) begin errors++; $display("FAIL mid_ferr_set got=%b exp=1", f0); end
        for (int i = 1; i < 8; i++) begin
            send_bit(w[i], 1'b0);
            if (i == 4) begin
                checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL mid_partial got=%b exp=0", v0); end
            end
        end
        checks++; if (v0 !== 1'b1 || d0 !== 8'h3C) begin errors++; $display("FAIL mid_word got=%b/%h exp=1/3c", v0, d0); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (f0 !== 1'b0) begin errors++; $display("FAIL mid_ferr_clear got=%b exp=0", f0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        send_word(8'h11, 1'b1, 0);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h11) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/11", v0, d0); end
        send_word(8'h22, 1'b0, 0);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h22) begin errors++; $display("FAIL b2b_second got=%b/%h exp=1/22", v0, d0); end
        checks++; if (f0 !== 1'b0 || o0 !== 1'b0) begin errors++; $display("FAIL b2b_flags got=%b%b exp=00", f0, o0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        send_word(8'h5A, 1'b1, 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h5A) begin errors++; $display("FAIL rmid_buffered got=%b/%h exp=1/5a", v0, d0); end
        do_reset();
        checks++; if (v0 !== 1'b0 || a0 !== 1'b0) begin errors++; $display("FAIL rmid_cleared got=%b%b exp=00", v0, a0); end
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL rmid_data got=%h exp=00", d0); end
        send_word(8'hFF, 1'b0, 0);
        checks++; if (v0 !== 1'b0 || a0 !== 1'b0) begin errors++; $display("FAIL rmid_discard got=%b%b exp=00", v0, a0); end
        send_word(8'h96, 1'b1, 0);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h96) begin errors++; $display("FAIL rmid_word got=%b/%h exp=1/96", v0, d0); end
    endtask

    initial begin
        rst = 1'b1;
        dataIn = 1'b0;
        sel = 1'b0;
        sync = 1'b0;
        out_ready = 1'b0;
        err_clr = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_msb();
        test_hunt();
        test_overflow();
        test_midword();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
